// File: rtl/load_store_unit.sv
// Load/store unit: execute-stage requests to Avalon-MM, lane steering, optional split of lane-crossing accesses.
// Latency: aligned load 3 cycles (1-cycle response), aligned store 2 cycles, fault pulse 1 cycle after accept.
// Backpressure: ready only in IDLE; avm_waitrequest stalls the command, each split adds one full beat.
module load_store_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [1:0]              i_size,          // 0 BYTE, 1 HALF, 2 WORD, 3 DOUBLE
  input  logic                    i_zero_extend,
  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [DATA_WIDTH-1:0]   i_to_bus,
  output logic [DATA_WIDTH-1:0]   o_from_bus,
  output logic                    o_ready,
  output logic                    o_done,
  output logic                    o_fault,
  output logic [ADDR_WIDTH-1:0]   o_avm_address,
  output logic [DATA_WIDTH/8-1:0] o_avm_byteenable,
  output logic                    o_avm_read,
  output logic                    o_avm_write,
  output logic [DATA_WIDTH-1:0]   o_avm_writedata,
  input  logic [DATA_WIDTH-1:0]   i_avm_readdata,
  input  logic                    i_avm_readdatavalid,
  input  logic                    i_avm_waitrequest
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_FAULT} state_t;

  state_t                  r_state, w_next_state;
  logic                    r_beat, r_split, r_zext, r_done;
  logic [OFS-1:0]          r_ofs;
  logic [3:0]              r_nbytes;
  logic [DATA_WIDTH-1:0]   r_data, r_asm, r_from_bus, r_avm_wdata;
  logic [ADDR_WIDTH-1:0]   r_avm_address;
  logic [BYTES-1:0]        r_avm_be;

  // Request decode, evaluated on the live inputs while IDLE
  logic [OFS-1:0]          w_req_ofs;
  logic [3:0]              w_req_nbytes;
  logic                    w_req_cross, w_req_illegal;
  logic [6:0]              w_req_sh;
  logic [BYTES-1:0]        w_req_be;
  assign w_req_ofs     = i_address[OFS-1:0];
  assign w_req_nbytes  = 4'd1 << i_size;
  assign w_req_cross   = (5'(w_req_ofs) + 5'(w_req_nbytes)) > 5'(BYTES);
  assign w_req_illegal = (i_size == 2'd3) && (DATA_WIDTH == 32);
  assign w_req_sh      = 7'(w_req_ofs) << 3;
  assign w_req_be      = BYTES'(((16'd1 << w_req_nbytes) - 16'd1) << w_req_ofs);

  // Latched-request datapath: beat-1 steering and load assembly/extension
  logic [6:0]              w_sh0, w_sh1, w_nbits;
  logic [BYTES-1:0]        w_be1;
  logic [DATA_WIDTH-1:0]   w_beat_val, w_keep, w_loaded;
  logic                    w_sign, w_final_beat;
  assign w_sh0        = 7'(r_ofs) << 3;
  assign w_sh1        = 7'(DATA_WIDTH) - w_sh0;   // bit position where beat-1 bytes land
  assign w_nbits      = 7'(r_nbytes) << 3;
  assign w_be1        = BYTES'((16'd1 << (5'(r_ofs) + 5'(r_nbytes) - 5'(BYTES))) - 16'd1);
  assign w_final_beat = r_beat || !r_split;
  assign w_beat_val   = r_beat ? (r_asm | (i_avm_readdata << w_sh1)) : (i_avm_readdata >> w_sh0);
  // keep = n-byte mask; (1 << DATA_WIDTH) - 1 wraps to all ones for full-width access
  assign w_keep       = ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << w_nbits) - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  // keep ^ (keep >> 1) isolates the top bit of the access, i.e. the sign bit
  assign w_sign       = |(w_beat_val & (w_keep ^ (w_keep >> 1)));
  assign w_loaded     = (r_zext || !w_sign) ? (w_beat_val & w_keep) : (w_beat_val | ~w_keep);

  logic w_accept, w_capture, w_advance, w_finish;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_read || i_write) begin
          if (w_req_illegal || (w_req_cross && (ALLOW_MISALIGNED == 0))) begin
            w_next_state = S_FAULT;
          end else begin
            w_accept     = 1'b1;
            w_next_state = i_read ? S_RD_REQ : S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (i_avm_readdatavalid)     w_capture    = 1'b1;
        else if (!i_avm_waitrequest) w_next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_avm_readdatavalid) w_capture = 1'b1;
      end
      S_WR_REQ: begin
        if (!i_avm_waitrequest) begin
          if (w_final_beat) begin
            w_finish     = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_advance    = 1'b1;
          end
        end
      end
      S_FAULT: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (w_capture) begin
      if (w_final_beat) begin
        w_finish     = 1'b1;
        w_next_state = S_IDLE;
      end else begin
        w_advance    = 1'b1;
        w_next_state = S_RD_REQ;
      end
    end
  end

  // Request latch, bus beat registers, load result and done pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat        <= 1'b0;
      r_split       <= 1'b0;
      r_zext        <= 1'b0;
      r_done        <= 1'b0;
      r_ofs         <= '0;
      r_nbytes      <= '0;
      r_data        <= '0;
      r_asm         <= '0;
      r_from_bus    <= '0;
      r_avm_address <= '0;
      r_avm_be      <= '0;
      r_avm_wdata   <= '0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_beat        <= 1'b0;
        r_split       <= w_req_cross;
        r_zext        <= i_zero_extend;
        r_ofs         <= w_req_ofs;
        r_nbytes      <= w_req_nbytes;
        r_data        <= i_to_bus;
        r_avm_address <= {i_address[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
        r_avm_be      <= w_req_be;
        r_avm_wdata   <= i_to_bus << w_req_sh;
      end
      if (w_advance) begin
        r_beat        <= 1'b1;
        r_avm_address <= r_avm_address + ADDR_WIDTH'(BYTES);
        r_avm_be      <= w_be1;
        r_avm_wdata   <= r_data >> w_sh1;
      end
      if (w_capture) begin
        if (w_final_beat) r_from_bus <= w_loaded;
        else              r_asm      <= w_beat_val;
      end
    end
  end

  assign o_ready          = (r_state == S_IDLE);
  assign o_avm_read       = (r_state == S_RD_REQ);
  assign o_avm_write      = (r_state == S_WR_REQ);
  assign o_fault          = (r_state == S_FAULT);
  assign o_done           = r_done;
  assign o_from_bus       = r_from_bus;
  assign o_avm_address    = r_avm_address;
  assign o_avm_byteenable = r_avm_be;
  assign o_avm_writedata  = r_avm_wdata;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit sitting between the core's execute stage and an Avalon-MM host port. It is the generalised successor of the single-width memory unit. It adds configurable data width (32/64) and lane steering for sub-word accesses at any byte offset. Misaligned accesses are either split into two bus transactions or reported as a fault, selected by parameter. A one-cycle completion pulse is also new.

## Interface
- DATA_WIDTH, 32: bus/register width in bits; legal values 32 or 64. BYTES = DATA_WIDTH/8, OFS = log2(BYTES).
- ADDR_WIDTH, 32: byte-address width.
- ALLOW_MISALIGNED, 1: 1 = split a lane-crossing access into two beats; 0 = fault it.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  byte address of the access.
- size  in  int_size_t  access size: BYTE, HALF, WORD, DOUBLE. DOUBLE is legal only when DATA_WIDTH==64.
- zero_extend  in  1  loads: 1 = zero-extend, 0 = sign-extend to DATA_WIDTH.
- read  in  1  load request, sampled only while ready.
- write  in  1  store request, sampled only while ready.
- to_bus  in  DATA_WIDTH  store data, right-aligned (LSB = first byte).
- from_bus  out  DATA_WIDTH  load result, right-aligned and extended.
- ready  out  1  unit idle; a request is accepted this cycle.
- done  out  1  one-cycle pulse: load result valid / store complete.
- fault  out  1  one-cycle pulse: request rejected, no bus activity.
- avm_address  out  ADDR_WIDTH  always BYTES-aligned.
- avm_byteenable  out  BYTES  lane mask.
- avm_read, avm_write  out  1  Avalon commands.
- avm_writedata  out  DATA_WIDTH  lane-steered store data.
- avm_readdata  in  DATA_WIDTH  agent read data.
- avm_readdatavalid  in  1  read response strobe.
- avm_waitrequest  in  1  agent stall.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FAULT. A beat flag (0/1) tracks split accesses.
- `ready` = (state==IDLE). `avm_read` = RD_REQ. `avm_write` = WR_REQ. `fault` = FAULT.
- Acceptance in IDLE: read has priority over write when both are high.
  - Define n = bytes(size), o = address[OFS-1:0].
  - Illegal size (DOUBLE with DATA_WIDTH 32) → FAULT.
  - o+n > BYTES with ALLOW_MISALIGNED=0 → FAULT.
  - Otherwise latch the request and go to RD_REQ or WR_REQ, beat 0.
- Beat 0:
  - avm_address = address with low OFS bits cleared.
  - avm_byteenable = ((1<<n)-1) << o, truncated to BYTES.
  - avm_writedata = to_bus << 8·o.
- Beat 1 (split only, o+n > BYTES):
  - avm_address = beat-0 address + BYTES.
  - avm_byteenable = (1<<(o+n-BYTES))-1.
  - avm_writedata = to_bus >> 8·(BYTES-o).
- RD_REQ:
  - avm_readdatavalid → capture the beat.
  - Otherwise avm_waitrequest → stay.
  - Otherwise → RD_WAIT.
- RD_WAIT: on avm_readdatavalid, capture the beat.
- Capture:
  - Beat 0 bytes come from readdata >> 8·o.
  - Beat 1 bytes fill positions BYTES-o upward.
  - After the last beat: from_bus = assembled value truncated to n bytes and extended; done=1; → IDLE.
  - After a non-final beat: → RD_REQ with beat 1.
- WR_REQ: when avm_waitrequest is low, the beat is complete.
  - Last beat → done=1, IDLE.
  - Otherwise → beat 1, stay in WR_REQ.
- FAULT: lasts one cycle, then → IDLE. from_bus is unchanged.
- from_bus holds its value until the next completed load.
- Address, size, zero_extend and to_bus are latched at acceptance. Later input changes have no effect.
- avm_readdatavalid while in IDLE, WR_REQ or FAULT is ignored.

## Timing
- Reset values (registered, applied at the clk edge with rst=1):
  - state=IDLE, so ready=1 and avm_read=avm_write=0.
  - from_bus=0, done=0, fault=0.
  - avm_address=0, avm_byteenable=0, avm_writedata=0.
- Reset mid-transaction: the command drops at the next edge and no done is produced. A late readdatavalid from the abandoned read is ignored.
- Aligned load, zero wait states, response one cycle after the command: accept at cycle 0, avm_read at cycle 1, readdatavalid at cycle 2, done and from_bus valid at cycle 3, ready again at cycle 3.
- Readdatavalid in the command cycle itself: done at cycle 2.
- Aligned store, no waitrequest: accept at 0, avm_write at 1, done and ready at 2.
- Each waitrequest cycle adds one cycle.
- A split access adds one full beat.
- Fault: accept at 0, fault=1 at cycle 1, ready at cycle 2.
- done and fault are never high together.

## Test plan
- Reset and load: DATA_WIDTH=32, address 0x1002, HALF load, sign-extend, readdata 0x8001_0000.
  - Expect avm_address 0x1000 and byteenable 0b1100.
  - Expect from_bus 0xFFFF_8001 with a one-cycle done.
- Zero-extended byte: byte load at 0x03, zero_extend=1, readdata 0xAB00_0000 → from_bus 0x0000_00AB.
- Split store: WORD store at 0x0006, to_bus 0x4433_2211, ALLOW_MISALIGNED=1.
  - Beat 0: 0x0004, be 0b1100, writedata 0x2211_0000.
  - Beat 1: 0x0008, be 0b0011, writedata 0x0000_4433.
  - 3 waitrequest cycles on beat 0 delay done by 3.
- Split load: word load at 0x0007, readdata 0x11xx_xxxx then 0xxx44_3322 → from_bus 0x4433_2211.
- Fault path: ALLOW_MISALIGNED=0, word load at 0x0001 → fault pulse, no avm_read, from_bus unchanged.
  - Also with DATA_WIDTH=32: DOUBLE size → fault.
- DATA_WIDTH=64 and reset: DOUBLE load at 0x10 with readdata 0x8877_6655_4433_2211 → be 0xFF, same from_bus.
  - Assert rst while RD_WAIT → ready next cycle and a late readdatavalid produces no done.
